// File: rtl/bcd_pkg.sv
// Shared BCD constants and FSM encoding for the BCD<->binary converters.
// Optional digit validation macro: BCD_TO_BINARY_DIGIT_CHECK_EN.
package bcd_pkg;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_VALUE  = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK_SHIFT,
    S_ADJUST,
    S_CHECK_DIGIT,
    S_DONE
  } state_t;

  function automatic logic digit_bad(
    input logic [BCD_DIGIT_W-1:0] d
  );
    return d > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse-double-dabble digit correction: d >= 8 -> d - 3.
// Four-bit wrap is intended; valid inputs never borrow.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= BCD_ADJ_THRESH)
                  ? digit - BCD_ADJ_VALUE
                  : digit;

endmodule

// File: rtl/bcd_to_binary.sv
// Multi-cycle packed-BCD to binary converter (reverse double dabble).
// Define BCD_TO_BINARY_DIGIT_CHECK_EN to flag digits > 9 on o_Error.
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int DECIMAL_DIGITS = 4,
  parameter int OUTPUT_WIDTH   = 14
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_n,
  input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
  input  logic                      i_Start,
  output logic [OUTPUT_WIDTH-1:0]   o_Binary,
  output logic                      o_DV,
  output logic                      o_Busy,
  output logic                      o_Overflow,
  output logic                      o_Error
);

  localparam int BW = DECIMAL_DIGITS * BCD_DIGIT_W;
  localparam int IW = (DECIMAL_DIGITS > 1)
                    ? $clog2(DECIMAL_DIGITS) : 1;

  localparam logic [7:0]    LAST_BIT = 8'(OUTPUT_WIDTH - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DECIMAL_DIGITS - 1);

  state_t                  state;
  logic [BW-1:0]           bcd;
  logic [OUTPUT_WIDTH-1:0] bin;
  logic [7:0]              loop_count;
  logic [IW-1:0]           idx;
  logic [BCD_DIGIT_W-1:0]  cur_digit;
  logic [BCD_DIGIT_W-1:0]  adj_digit;

  assign cur_digit = bcd[idx*BCD_DIGIT_W +: BCD_DIGIT_W];

  bcd_digit_adjust u_adjust (
    .digit    (cur_digit),
    .adjusted (adj_digit)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state      <= S_IDLE;
      bcd        <= '0;
      bin        <= '0;
      loop_count <= '0;
      idx        <= '0;
      o_Binary   <= '0;
      o_Overflow <= 1'b0;
      o_DV       <= 1'b0;
      o_Busy     <= 1'b0;
    end else begin
      o_DV <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_Start) begin
            bcd    <= i_BCD;
            bin    <= '0;
            o_Busy <= 1'b1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // bcd LSB falls into the binary MSB
          {bcd, bin} <= {bcd, bin} >> 1;
          state      <= S_CHECK_SHIFT;
        end
        S_CHECK_SHIFT: begin
          if (loop_count == LAST_BIT) begin
            loop_count <= '0;
            state      <= S_DONE;
          end else begin
            loop_count <= loop_count + 8'd1;
            state      <= S_ADJUST;
          end
        end
        S_ADJUST: begin
          bcd[idx*BCD_DIGIT_W +: BCD_DIGIT_W] <= adj_digit;
          state <= S_CHECK_DIGIT;
        end
        S_CHECK_DIGIT: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= S_SHIFT;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_ADJUST;
          end
        end
        S_DONE: begin
          o_Binary   <= bin;
          o_Overflow <= |bcd;
          o_DV       <= 1'b1;
          o_Busy     <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
  logic bad_now;
  logic bad_seen;

  always_comb begin
    bad_now = 1'b0;
    for (int i = 0; i < DECIMAL_DIGITS; i++)
      bad_now |= digit_bad(i_BCD[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      bad_seen <= 1'b0;
      o_Error  <= 1'b0;
    end else begin
      if (state == S_IDLE && i_Start)
        bad_seen <= bad_now;
      if (state == S_DONE)
        o_Error <= bad_seen;
    end
  end
`else
  assign o_Error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// Bench for bcd_to_binary: 8-bit/3-digit and 14-bit/4-digit instances
// checked each cycle against a decimal-arithmetic latency model.
module tb_bcd_to_binary;

`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic [11:0] bcd_a = '0;
  logic        start_a = 1'b0;
  logic [7:0]  bin_a;
  logic        dv_a, busy_a, ovf_a, err_a;

  logic [15:0] bcd_b = '0;
  logic        start_b = 1'b0;
  logic [13:0] bin_b;
  logic        dv_b, busy_b, ovf_b, err_b;

  bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(8)) dut_a (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_BCD(bcd_a),
    .i_Start(start_a), .o_Binary(bin_a), .o_DV(dv_a),
    .o_Busy(busy_a), .o_Overflow(ovf_a), .o_Error(err_a)
  );

  bcd_to_binary #(.DECIMAL_DIGITS(4), .OUTPUT_WIDTH(14)) dut_b (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_BCD(bcd_b),
    .i_Start(start_b), .o_Binary(bin_b), .o_DV(dv_b),
    .o_Busy(busy_b), .o_Overflow(ovf_b), .o_Error(err_b)
  );

  int checks = 0;
  int failures = 0;

  int     dd[2] = '{3, 4};
  int     ow[2] = '{8, 14};
  int     cnt[2];
  longint val[2];
  bit     bad[2];
  bit     e_dv[2], e_busy[2], e_ovf[2], e_err[2];
  longint e_bin[2];
  bit     known[2];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int lat(int k);
    return 2*ow[k] + 2*dd[k]*(ow[k]-1) + 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; val[k] = 0; bad[k] = 0;
      e_dv[k] = 0; e_busy[k] = 0; e_ovf[k] = 0;
      e_err[k] = 0; e_bin[k] = 0; known[k] = 1;
    end
  endtask

  // Conversion = decimal value of the digits, mod 2^width, after a fixed delay
  task automatic model_step(int k, bit st, logic [63:0] b);
    logic [3:0] d;
    e_dv[k] = 0;
    if (cnt[k] > 0) begin
      cnt[k]--;
      if (cnt[k] == 0) begin
        e_dv[k]  = 1;
        e_bin[k] = val[k] % (longint'(1) << ow[k]);
        e_ovf[k] = (val[k] >> ow[k]) != 0;
        e_err[k] = ERR_EN && bad[k];
        known[k] = !bad[k];
      end
    end else if (st) begin
      cnt[k] = lat(k);
      val[k] = 0;
      bad[k] = 0;
      for (int i = dd[k]-1; i >= 0; i--) begin
        d = b[i*4 +: 4];
        if (d > 9) bad[k] = 1;
        val[k] = val[k]*10 + d;
      end
    end
    e_busy[k] = cnt[k] != 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        model_step(0, start_a, 64'(bcd_a));
        model_step(1, start_b, 64'(bcd_b));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("a_dv", 64'(dv_a), 64'(e_dv[0]));
    chk("a_busy", 64'(busy_a), 64'(e_busy[0]));
    chk("a_err", 64'(err_a), 64'(e_err[0]));
    if (known[0]) begin
      chk("a_bin", 64'(bin_a), 64'(e_bin[0]));
      chk("a_ovf", 64'(ovf_a), 64'(e_ovf[0]));
    end
    chk("b_dv", 64'(dv_b), 64'(e_dv[1]));
    chk("b_busy", 64'(busy_b), 64'(e_busy[1]));
    chk("b_err", 64'(err_b), 64'(e_err[1]));
    if (known[1]) begin
      chk("b_bin", 64'(bin_b), 64'(e_bin[1]));
      chk("b_ovf", 64'(ovf_b), 64'(e_ovf[1]));
    end
  end

  task automatic drive(int k, logic [63:0] b, logic st);
    if (k == 0) begin bcd_a = b[11:0]; start_a = st; end
    else begin bcd_b = b[15:0]; start_b = st; end
  endtask

  function automatic logic get_dv(int k);
    return (k == 0) ? dv_a : dv_b;
  endfunction

  task automatic conv(int k, logic [63:0] b,
                      output logic [63:0] rbin,
                      output logic rovf, output logic rerr,
                      output int n);
    bit seen;
    @(posedge clk); #1;
    drive(k, b, 1'b1);
    @(posedge clk); #1;
    drive(k, b, 1'b0);
    seen = 0; n = 0; rbin = '0; rovf = 0; rerr = 0;
    for (int c = 1; c <= lat(k) + 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (get_dv(k)) begin
        seen = 1; n = c;
        rbin = (k == 0) ? 64'(bin_a) : 64'(bin_b);
        rovf = (k == 0) ? ovf_a : ovf_b;
        rerr = (k == 0) ? err_a : err_b;
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL dv_timeout dut=%0d actual=none expected=dv", k);
    end
  endtask

  task automatic wait_cycles(int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  logic [63:0] rb;
  logic        ro, re;
  int          n, dvs;
  logic [63:0] rnd;

  initial begin
    wait_cycles(3);
    chk("rst_bin", 64'(bin_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_dv", 64'(dv_b), 64'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    conv(0, 64'h255, rb, ro, re, n);
    chk("t1_latency", 64'(n), 64'd59);
    chk("t1_bin", rb, 64'd255);
    chk("t1_ovf", 64'(ro), 64'd0);
    chk("t1_err", 64'(re), 64'd0);

    conv(0, 64'h256, rb, ro, re, n);
    chk("t2_bin", rb, 64'd0);
    chk("t2_ovf", 64'(ro), 64'd1);
    conv(0, 64'h000, rb, ro, re, n);
    chk("t2_zero_bin", rb, 64'd0);
    chk("t2_zero_ovf", 64'(ro), 64'd0);

    conv(0, 64'h1A5, rb, ro, re, n);
    chk("t3_err", 64'(re), 64'(ERR_EN));

    // Second start mid-conversion must be ignored
    @(posedge clk); #1;
    drive(0, 64'h123, 1'b1);
    @(posedge clk); #1;
    drive(0, 64'h123, 1'b0);
    wait_cycles(10);
    drive(0, 64'h045, 1'b1);
    @(posedge clk); #1;
    drive(0, 64'h045, 1'b0);
    dvs = 0;
    for (int c = 0; c < 130; c++) begin
      @(posedge clk); #1;
      if (dv_a) begin
        dvs++;
        chk("t4_bin", 64'(bin_a), 64'd123);
      end
    end
    chk("t4_dv_count", 64'(dvs), 64'd1);

    // Reset in the middle of a conversion
    @(posedge clk); #1;
    drive(0, 64'h777, 1'b1);
    @(posedge clk); #1;
    drive(0, 64'h777, 1'b0);
    wait_cycles(20);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy_a), 64'd0);
    chk("t5_bin", 64'(bin_a), 64'd0);
    chk("t5_dv", 64'(dv_a), 64'd0);
    wait_cycles(2);
    rst_n = 1'b1;
    dvs = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (dv_a) dvs++;
    end
    chk("t5_no_dv", 64'(dvs), 64'd0);
    conv(0, 64'h099, rb, ro, re, n);
    chk("t5_bin_99", rb, 64'd99);

    conv(1, 64'h9999, rb, ro, re, n);
    chk("t6_latency", 64'(n), 64'd133);
    chk("t6_bin", rb, 64'd9999);
    chk("t6_ovf", 64'(ro), 64'd0);
    conv(1, 64'h0000, rb, ro, re, n);
    chk("t6_zero", rb, 64'd0);

    for (int t = 0; t < 150; t++) begin
      rnd = '0;
      for (int i = 0; i < 4; i++)
        rnd[i*4 +: 4] = 4'($urandom_range(0, 9));
      conv(1, rnd, rb, ro, re, n);
      chk("t6_rand_ovf", 64'(ro), 64'd0);
    end

    for (int t = 0; t < 80; t++) begin
      rnd = '0;
      for (int i = 0; i < 3; i++)
        rnd[i*4 +: 4] = ($urandom_range(0, 7) == 0)
                      ? 4'($urandom_range(10, 15))
                      : 4'($urandom_range(0, 9));
      conv(0, rnd, rb, ro, re, n);
    end

    // Start held high: back-to-back conversions
    @(posedge clk); #1;
    drive(0, 64'h187, 1'b1);
    dvs = 0;
    for (int c = 0; c < 125; c++) begin
      @(posedge clk); #1;
      if (dv_a) dvs++;
    end
    drive(0, 64'h187, 1'b0);
    chk("b2b_dv_count", 64'(dvs), 64'd2);
    wait_cycles(70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
